or1200_fwd_ctrl: RTL and testbench
==================================

Name: or1200_fwd_ctrl

Overview:
Forwarding and hazard controller that drives the sel_a/sel_b selects of the operand muxes. Tracks destination register and write-enable of the ID, EX and WB pipeline occupants through the freeze pattern. Selects ex_forw/wb_forw/rf/simm per source operand. Detects load-use hazards and requests a one-cycle stall.

Parameters:
AW, 5, register address width
CNT_W, 16, statistics counter width (optional feature only)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_freeze  in  1  ID stage hold; ex_freeze=1 implies id_freeze=1
ex_freeze  in  1  EX stage hold
dcd_rfa_addr  in  AW  source A address of instruction entering ID
dcd_rfb_addr  in  AW  source B address of instruction entering ID
dcd_rfa_used  in  1  source A read by entering instruction
dcd_rfb_used  in  1  source B read by entering instruction
dcd_imm  in  1  operand B is immediate (simm)
dcd_rfwb_addr  in  AW  destination of entering instruction
dcd_rfwb_we  in  1  entering instruction writes the register file
dcd_load  in  1  entering instruction is a load
sel_a  out  2  operand A select: 0 rf, 2 ex_forw, 3 wb_forw
sel_b  out  2  operand B select: 0 rf, 1 simm, 2 ex_forw, 3 wb_forw
lu_stall  out  1  load-use stall request to freeze logic

Behaviour:
- Occupant state, one slot each for ID, EX, WB: {addr, we, load; ID also srcs/used/imm}.
- Per-edge update, priority order:
  - rst: all slots cleared, we=0.
  - !ex_freeze && !id_freeze: dcd->ID, ID->EX, EX->WB.
  - id_freeze && !ex_freeze: ID holds, bubble (we=0) ->EX, EX->WB.
  - both frozen: all slots hold.
  - !id_freeze && ex_freeze is illegal; outputs unspecified.
- sel_a/sel_b are registered and recomputed every edge from the next-state slots. They are therefore valid in the cycle the consumer sits in ID.
- Select rule, operand X with address s and used u, where "matches slot" = u && slot.we && slot.addr==s && s!=0:
  - matches next-EX -> 2'd2.
  - else matches next-WB -> 2'd3.
  - else -> 2'd0.
  - EX has priority over WB.
  - Operand B with imm=1 -> 2'd1 regardless of matches.
  - r0 is never forwarded.
- lu_stall is combinational from registered state: ID operand matches the EX slot (same match rule, imm excluded for B) && EX.load.
- Load-use FSM, 2 states:
  - RUN -> LU: on lu_stall && !ex_freeze. The bubble edge moves the load to WB, and sel is recomputed to 2'd3.
  - LU -> RUN: next edge without ex_freeze.
  - In LU, lu_stall is 0 by construction. A second hazard cannot re-enter LU without an intervening EX advance.
  - ex_freeze while in RUN with lu_stall=1: stay RUN, hold lu_stall.
- Reset values: sel_a=0, sel_b=0, lu_stall=0, FSM=RUN, all counters 0.
- rst mid-stall: FSM->RUN and all slots cleared next edge; no residual stall.
- Latency: selects reflect a new ID occupant in the same cycle it enters ID (0 cycles after capture edge).

Optional Feature:
Macro OR1200_FWD_CNT_EN.
- Defined: adds outputs fwd_cnt[CNT_W-1:0] and lu_cnt[CNT_W-1:0].
  - fwd_cnt increments by the number of operands (0-2) selecting 2 or 3 on each edge where !id_freeze.
  - lu_cnt increments once per RUN->LU transition.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- rst held 2 cycles, then released with idle inputs -> sel_a=0, sel_b=0, lu_stall=0; counters 0.
- ADD r3 then SUB r5,r3,r4 back-to-back, no freeze -> consumer in ID sees sel_a=2, sel_b=0; next: third instr using r3 on B -> sel_b=3.
- LOAD r7 then ADD r8,r7,r7 -> lu_stall=1 one cycle, bubble inserted, then sel_a=3, sel_b=3, lu_stall=0; lu_cnt=1.
- Write to r0 followed by reader of r0 -> sel_a=0 (no forward).
- EX and WB both write r4, consumer reads r4 on A; B immediate -> sel_a=2, sel_b=1.
- Both freezes held 3 cycles during a pending forward -> sel values and lu_stall hold unchanged. rst asserted while FSM=LU -> next cycle lu_stall=0, sel=0.

Source files
------------

// File: rtl/or1200_fwd_ctrl.sv
// rtl/or1200_fwd_ctrl.sv - operand forwarding select and load-use stall controller
// Optional statistics counters enabled by defining OR1200_FWD_CNT_EN.
module or1200_fwd_ctrl #(
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_freeze,
  input  logic          ex_freeze,
  input  logic [AW-1:0] dcd_rfa_addr,
  input  logic [AW-1:0] dcd_rfb_addr,
  input  logic          dcd_rfa_used,
  input  logic          dcd_rfb_used,
  input  logic          dcd_imm,
  input  logic [AW-1:0] dcd_rfwb_addr,
  input  logic          dcd_rfwb_we,
  input  logic          dcd_load,
  output logic [1:0]    sel_a,
  output logic [1:0]    sel_b,
  output logic          lu_stall
`ifdef OR1200_FWD_CNT_EN
  ,
  output logic [CNT_W-1:0] fwd_cnt,
  output logic [CNT_W-1:0] lu_cnt
`endif
);

  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] LU  = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] id_a, id_b, id_wb, ex_wb, wb_wb;
  logic          id_au, id_bu, id_imm, id_we, id_ld;
  logic          ex_we, ex_ld, wb_we;

  logic [AW-1:0] n_id_a, n_id_b, n_id_wb, n_ex_wb, n_wb_wb;
  logic          n_id_au, n_id_bu, n_id_imm, n_id_we, n_id_ld;
  logic          n_ex_we, n_ex_ld, n_wb_we;
  logic [1:0]    n_sel_a, n_sel_b;
  logic          stall_raw;

  function automatic logic hit(input logic [AW-1:0] s, input logic u,
                               input logic we, input logic [AW-1:0] d);
    return u && we && (d == s) && (s != '0);
  endfunction

  function automatic logic [1:0] pick(input logic [AW-1:0] s, input logic u,
                                      input logic exw, input logic [AW-1:0] exd,
                                      input logic wbw, input logic [AW-1:0] wbd);
    if (hit(s, u, exw, exd))      return 2'd2;
    else if (hit(s, u, wbw, wbd)) return 2'd3;
    else                          return 2'd0;
  endfunction

  always_comb begin
    n_id_a   = id_a;   n_id_b  = id_b;  n_id_au = id_au; n_id_bu = id_bu;
    n_id_imm = id_imm; n_id_wb = id_wb; n_id_we = id_we; n_id_ld = id_ld;
    n_ex_wb  = ex_wb;  n_ex_we = ex_we; n_ex_ld = ex_ld;
    n_wb_wb  = wb_wb;  n_wb_we = wb_we;
    if (!ex_freeze && !id_freeze) begin
      n_id_a   = dcd_rfa_addr;  n_id_b  = dcd_rfb_addr;
      n_id_au  = dcd_rfa_used;  n_id_bu = dcd_rfb_used;
      n_id_imm = dcd_imm;       n_id_wb = dcd_rfwb_addr;
      n_id_we  = dcd_rfwb_we;   n_id_ld = dcd_load;
      n_ex_wb  = id_wb; n_ex_we = id_we; n_ex_ld = id_ld;
      n_wb_wb  = ex_wb; n_wb_we = ex_we;
    end else if (!ex_freeze) begin
      // ID held: a bubble enters EX while the old EX occupant retires to WB
      n_ex_wb  = '0;    n_ex_we = 1'b0;  n_ex_ld = 1'b0;
      n_wb_wb  = ex_wb; n_wb_we = ex_we;
    end
    n_sel_a = pick(n_id_a, n_id_au, n_ex_we, n_ex_wb, n_wb_we, n_wb_wb);
    n_sel_b = n_id_imm ? 2'd1
                       : pick(n_id_b, n_id_bu, n_ex_we, n_ex_wb, n_wb_we, n_wb_wb);
  end

  assign stall_raw = ex_ld && (hit(id_a, id_au, ex_we, ex_wb) ||
                               (!id_imm && hit(id_b, id_bu, ex_we, ex_wb)));
  assign lu_stall  = stall_raw && (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_a <= '0; id_b <= '0; id_au <= 1'b0; id_bu <= 1'b0; id_imm <= 1'b0;
      id_wb <= '0; id_we <= 1'b0; id_ld <= 1'b0;
      ex_wb <= '0; ex_we <= 1'b0; ex_ld <= 1'b0;
      wb_wb <= '0; wb_we <= 1'b0;
      sel_a <= 2'd0; sel_b <= 2'd0;
      state <= RUN;
    end else begin
      id_a <= n_id_a; id_b <= n_id_b; id_au <= n_id_au; id_bu <= n_id_bu;
      id_imm <= n_id_imm; id_wb <= n_id_wb; id_we <= n_id_we; id_ld <= n_id_ld;
      ex_wb <= n_ex_wb; ex_we <= n_ex_we; ex_ld <= n_ex_ld;
      wb_wb <= n_wb_wb; wb_we <= n_wb_we;
      sel_a <= n_sel_a; sel_b <= n_sel_b;
      if (state == RUN) begin
        if (lu_stall && !ex_freeze) state <= LU;
      end else if (!ex_freeze) begin
        state <= RUN;
      end
    end
  end

`ifdef OR1200_FWD_CNT_EN
  logic [1:0]     fwd_inc;
  logic [CNT_W:0] fwd_sum;

  assign fwd_inc = {1'b0, n_sel_a[1]} + {1'b0, n_sel_b[1]};
  assign fwd_sum = {1'b0, fwd_cnt} + {{(CNT_W-1){1'b0}}, fwd_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt <= '0;
      lu_cnt  <= '0;
    end else begin
      if (!id_freeze)
        fwd_cnt <= fwd_sum[CNT_W] ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
      if ((state == RUN) && lu_stall && !ex_freeze && !(&lu_cnt))
        lu_cnt <= lu_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_or1200_fwd_ctrl.sv
// tb/tb_or1200_fwd_ctrl.sv - directed vector bench for or1200_fwd_ctrl
// Counter checks compile in when OR1200_FWD_CNT_EN is defined.
module tb_or1200_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst, id_freeze, ex_freeze;
  logic [4:0] dcd_rfa_addr, dcd_rfb_addr, dcd_rfwb_addr;
  logic       dcd_rfa_used, dcd_rfb_used, dcd_imm, dcd_rfwb_we, dcd_load;
  logic [1:0] sel_a, sel_b;
  logic       lu_stall;
`ifdef OR1200_FWD_CNT_EN
  logic [15:0] fwd_cnt, lu_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  or1200_fwd_ctrl #(.AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_freeze(id_freeze), .ex_freeze(ex_freeze),
    .dcd_rfa_addr(dcd_rfa_addr), .dcd_rfb_addr(dcd_rfb_addr),
    .dcd_rfa_used(dcd_rfa_used), .dcd_rfb_used(dcd_rfb_used),
    .dcd_imm(dcd_imm), .dcd_rfwb_addr(dcd_rfwb_addr),
    .dcd_rfwb_we(dcd_rfwb_we), .dcd_load(dcd_load),
    .sel_a(sel_a), .sel_b(sel_b), .lu_stall(lu_stall)
`ifdef OR1200_FWD_CNT_EN
    , .fwd_cnt(fwd_cnt), .lu_cnt(lu_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, idf, exf;
    logic [4:0] a, b;
    logic       au, bu, imm;
    logic [4:0] wb;
    logic       we, ld;
    logic [1:0] ea, eb;
    logic       el;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t v(input logic r, input logic idf, input logic exf,
                             input logic [4:0] a, input logic au,
                             input logic [4:0] b, input logic bu, input logic imm,
                             input logic [4:0] wb, input logic we, input logic ld,
                             input logic [1:0] ea, input logic [1:0] eb, input logic el);
    vec_t t;
    t.rst = r; t.idf = idf; t.exf = exf; t.a = a; t.au = au; t.b = b; t.bu = bu;
    t.imm = imm; t.wb = wb; t.we = we; t.ld = ld; t.ea = ea; t.eb = eb; t.el = el;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    rst = t.rst; id_freeze = t.idf; ex_freeze = t.exf;
    dcd_rfa_addr = t.a; dcd_rfa_used = t.au; dcd_rfb_addr = t.b; dcd_rfb_used = t.bu;
    dcd_imm = t.imm; dcd_rfwb_addr = t.wb; dcd_rfwb_we = t.we; dcd_load = t.ld;
  endtask

  initial begin
    //             rst idf exf  a  au  b  bu imm  wb we ld  ea    eb    el
    vecs[0]  = v(0, 0, 0,  1, 1,  2, 1, 0,  3, 1, 0, 2'd0, 2'd0, 0); // ADD r3
    vecs[1]  = v(0, 0, 0,  3, 1,  4, 1, 0,  5, 1, 0, 2'd2, 2'd0, 0); // SUB r5,r3,r4
    vecs[2]  = v(0, 0, 0,  1, 1,  3, 1, 0,  6, 1, 0, 2'd0, 2'd3, 0); // r3 on B from WB
    vecs[3]  = v(0, 0, 0,  1, 1,  0, 0, 1,  7, 1, 1, 2'd0, 2'd1, 0); // LOAD r7
    vecs[4]  = v(0, 0, 0,  7, 1,  7, 1, 0,  8, 1, 0, 2'd2, 2'd2, 1); // ADD r8,r7,r7
    vecs[5]  = v(0, 1, 0,  0, 0,  0, 0, 0,  0, 0, 0, 2'd3, 2'd3, 0); // bubble edge
    vecs[6]  = v(0, 0, 0,  1, 1,  0, 0, 0,  0, 1, 0, 2'd0, 2'd0, 0); // write r0
    vecs[7]  = v(0, 0, 0,  0, 1,  0, 1, 0,  9, 1, 0, 2'd0, 2'd0, 0); // read r0
    vecs[8]  = v(0, 0, 0,  1, 1,  0, 0, 0,  4, 1, 0, 2'd0, 2'd0, 0); // write r4
    vecs[9]  = v(0, 0, 0,  2, 1,  0, 0, 0,  4, 1, 0, 2'd0, 2'd0, 0); // write r4 again
    vecs[10] = v(0, 0, 0,  4, 1,  4, 1, 1, 10, 1, 0, 2'd2, 2'd1, 0); // EX beats WB, B imm
    vecs[11] = v(0, 1, 1, 30, 1, 30, 1, 0, 30, 1, 1, 2'd2, 2'd1, 0); // full freeze x3
    vecs[12] = v(0, 1, 1, 30, 1, 30, 1, 0, 30, 1, 1, 2'd2, 2'd1, 0);
    vecs[13] = v(0, 1, 1, 30, 1, 30, 1, 0, 30, 1, 1, 2'd2, 2'd1, 0);
    vecs[14] = v(0, 0, 0,  1, 1,  0, 0, 1, 11, 1, 1, 2'd0, 2'd1, 0); // LOAD r11
    vecs[15] = v(0, 0, 0, 11, 1,  5, 0, 0, 12, 1, 0, 2'd2, 2'd0, 1); // use r11
    vecs[16] = v(0, 1, 1,  0, 0,  0, 0, 0,  0, 0, 0, 2'd2, 2'd0, 1); // freeze holds stall
    vecs[17] = v(0, 1, 1,  0, 0,  0, 0, 0,  0, 0, 0, 2'd2, 2'd0, 1);
    vecs[18] = v(0, 1, 0,  0, 0,  0, 0, 0,  0, 0, 0, 2'd3, 2'd0, 0); // bubble, FSM in LU
    vecs[19] = v(1, 0, 0, 11, 1, 11, 1, 0, 11, 1, 1, 2'd0, 2'd0, 0); // rst while LU
    vecs[20] = v(0, 0, 0, 11, 1, 11, 1, 0,  1, 1, 0, 2'd0, 2'd0, 0); // no residual

    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel_a", -1, sel_a, 0);
    check("rst_sel_b", -1, sel_b, 0);
    check("rst_lu_stall", -1, lu_stall, 0);
`ifdef OR1200_FWD_CNT_EN
    check("rst_fwd_cnt", -1, fwd_cnt, 0);
    check("rst_lu_cnt", -1, lu_cnt, 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_sel_a", -1, sel_a, 0);
    check("idle_sel_b", -1, sel_b, 0);
    check("idle_lu_stall", -1, lu_stall, 0);

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i]);
      @(posedge clk);
      #1;
      check("sel_a", i, sel_a, vecs[i].ea);
      check("sel_b", i, sel_b, vecs[i].eb);
      check("lu_stall", i, lu_stall, vecs[i].el);
`ifdef OR1200_FWD_CNT_EN
      if (i == 5) check("lu_cnt_first", i, lu_cnt, 1);
      if (i == 19) check("lu_cnt_rst", i, lu_cnt, 0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
